// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory with a fixed access length.
// Tie policy: dm always wins, or round-robin when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_port_arbiter #(
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       grant_if_s;
    logic       grant_dm_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic       last_dm_r;

    // Grant selection: a tie goes to the port not served most recently
    always_comb begin
        grant_if_s = 1'b0;
        grant_dm_s = 1'b0;
        if (state_r == IDLE) begin
            if (if_req && dm_req) begin
                if (last_dm_r) begin
                    grant_if_s = 1'b1;
                end else begin
                    grant_dm_s = 1'b1;
                end
            end else if (dm_req) begin
                grant_dm_s = 1'b1;
            end else if (if_req) begin
                grant_if_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
        end
    end

    // Last-grant tracker; starts as "dm" so the first tie is handed to fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dm_r <= 1'b1;
        end else if (grant_dm_s) begin
            last_dm_r <= 1'b1;
        end else if (grant_if_s) begin
            last_dm_r <= 1'b0;
        end else begin
            last_dm_r <= last_dm_r;
        end
    end
`else
    // Grant selection: data port wins every tie so the older instruction drains first
    always_comb begin
        grant_if_s = 1'b0;
        grant_dm_s = 1'b0;
        if (state_r == IDLE) begin
            if (dm_req) begin
                grant_dm_s = 1'b1;
            end else if (if_req) begin
                grant_if_s = 1'b1;
            end else begin
                grant_dm_s = 1'b0;
            end
        end else begin
            grant_dm_s = 1'b0;
        end
    end
`endif

    // Stall is purely combinational so a requester sees release in its valid cycle
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    // Access FSM: latch the granted request, hold the memory bus, then return data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            if_valid  <= 1'b0;
            dm_rdata  <= 32'd0;
            dm_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_dm_s) begin
                        state_r   <= BUSY_DM;
                        cnt_r     <= CNT_LOAD;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant_if_s) begin
                        // Fetches never write, whatever the data port is presenting
                        state_r  <= BUSY_IF;
                        cnt_r    <= CNT_LOAD;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end else begin
                        mem_en <= 1'b0;
                    end
                end
                BUSY_IF: begin
                    if (cnt_r == 4'd0) begin
                        state_r  <= IDLE;
                        mem_en   <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                BUSY_DM: begin
                    if (cnt_r == 4'd0) begin
                        state_r  <= IDLE;
                        mem_en   <= 1'b0;
                        dm_valid <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end else begin
                            dm_rdata <= dm_rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    mem_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (WAIT_CYC=2) with a completion scoreboard.
// Tie checks follow MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid, dm_stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        got_e;
    int          checks = 0;
    int          failures = 0;
    logic        use_model;
    logic [31:0] mem_fixed;

    always #5 clk = ~clk;

    // Memory stand-in: either a fixed word or an address-derived pattern
    assign mem_rdata = use_model ? {mem_addr[15:0], ~mem_addr[15:0]} : mem_fixed;

    mem_port_arbiter #(.WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (if_valid === 1'b1 || dm_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {30'd0, if_valid, dm_valid}, 32'd0);
            end else begin
                got_e = exp_q.pop_front();
                chk("sb_port", {31'd0, dm_valid}, {31'd0, got_e.is_dm});
                chk("sb_rdata", got_e.is_dm ? dm_rdata : if_rdata, got_e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        use_model = 1'b0; mem_fixed = 32'd0;
        cyc(); cyc(); samp();
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        cyc(); rst = 1'b0;

        // Fetch with late address change and dm_we asserted on the idle data port
        cyc(); if_req = 1'b1; if_addr = 32'h10; dm_we = 1'b1; mem_fixed = 32'hDEADBEEF;
        exp_q.push_back('{1'b0, 32'hDEADBEEF});
        samp();
        chk("f0_stall", {31'd0, if_stall}, 32'd1);
        chk("f0_mem_en", {31'd0, mem_en}, 32'd0);
        cyc(); if_addr = 32'h99; samp();
        chk("f1_mem_en", {31'd0, mem_en}, 32'd1);
        chk("f1_mem_addr", mem_addr, 32'h10);
        chk("f1_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f1_stall", {31'd0, if_stall}, 32'd1);
        cyc(); samp();
        chk("f2_mem_en", {31'd0, mem_en}, 32'd1);
        chk("f2_mem_addr", mem_addr, 32'h10);
        chk("f2_valid", {31'd0, if_valid}, 32'd0);
        cyc(); samp();
        chk("f3_valid", {31'd0, if_valid}, 32'd1);
        chk("f3_rdata", if_rdata, 32'hDEADBEEF);
        chk("f3_stall", {31'd0, if_stall}, 32'd0);
        chk("f3_mem_en", {31'd0, mem_en}, 32'd0);
        if_req = 1'b0;
        cyc(); samp();
        chk("f4_valid", {31'd0, if_valid}, 32'd0);
        chk("f4_rdata_hold", if_rdata, 32'hDEADBEEF);
        chk("f4_mem_en", {31'd0, mem_en}, 32'd0);

        // Data read, then a write that must leave dm_rdata alone
        cyc(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; mem_fixed = 32'h12345678;
        exp_q.push_back('{1'b1, 32'h12345678});
        samp();
        chk("r0_stall", {31'd0, dm_stall}, 32'd1);
        cyc(); cyc(); cyc(); samp();
        chk("r3_valid", {31'd0, dm_valid}, 32'd1);
        chk("r3_rdata", dm_rdata, 32'h12345678);
        dm_req = 1'b0;
        cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h55;
        mem_fixed = 32'h0BADC0DE;
        exp_q.push_back('{1'b1, 32'h12345678});
        samp();
        cyc(); dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; samp();
        chk("w1_mem_we", {31'd0, mem_we}, 32'd1);
        chk("w1_mem_addr", mem_addr, 32'h40);
        chk("w1_mem_wdata", mem_wdata, 32'h55);
        chk("w1_mem_en", {31'd0, mem_en}, 32'd1);
        cyc(); samp();
        chk("w2_mem_we", {31'd0, mem_we}, 32'd1);
        chk("w2_mem_en", {31'd0, mem_en}, 32'd1);
        cyc(); samp();
        chk("w3_valid", {31'd0, dm_valid}, 32'd1);
        chk("w3_rdata_kept", dm_rdata, 32'h12345678);
        cyc(); samp();
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
        chk("idle_addr_hold", mem_addr, 32'h40);
        chk("idle_we_hold", {31'd0, mem_we}, 32'd1);

        // Simultaneous requests
        use_model = 1'b1;
        cyc(); if_req = 1'b1; if_addr = 32'h30; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h50;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{k[0], (k[0] ? model(32'h50) : model(32'h30))});
        end
        samp();
        for (int k = 1; k <= 12; k++) begin
            cyc(); samp();
            chk("rr_if_valid", {31'd0, if_valid}, {31'd0, (k == 3 || k == 9)});
            chk("rr_dm_valid", {31'd0, dm_valid}, {31'd0, (k == 6 || k == 12)});
            if (k == 1) chk("rr_first_addr", mem_addr, 32'h30);
        end
        if_req = 1'b0; dm_req = 1'b0;
`else
        exp_q.push_back('{1'b1, model(32'h50)});
        exp_q.push_back('{1'b0, model(32'h30)});
        samp();
        chk("t0_if_stall", {31'd0, if_stall}, 32'd1);
        cyc(); samp();
        chk("t1_mem_addr", mem_addr, 32'h50);
        cyc(); cyc(); samp();
        chk("t3_dm_valid", {31'd0, dm_valid}, 32'd1);
        chk("t3_if_stall", {31'd0, if_stall}, 32'd1);
        dm_req = 1'b0;
        cyc(); samp();
        chk("t4_mem_addr", mem_addr, 32'h30);
        chk("t4_mem_en", {31'd0, mem_en}, 32'd1);
        cyc(); samp();
        chk("t5_if_stall", {31'd0, if_stall}, 32'd1);
        cyc(); samp();
        chk("t6_if_valid", {31'd0, if_valid}, 32'd1);
        chk("t6_if_stall", {31'd0, if_stall}, 32'd0);
        if_req = 1'b0;
`endif

        // Reset in the middle of a fetch aborts it
        cyc(); cyc(); if_req = 1'b1; if_addr = 32'h60; samp();
        cyc(); rst = 1'b1; samp();
        chk("a1_mem_en", {31'd0, mem_en}, 32'd1);
        cyc(); if_req = 1'b0; samp();
        chk("a2_mem_en", {31'd0, mem_en}, 32'd0);
        chk("a2_if_valid", {31'd0, if_valid}, 32'd0);
        chk("a2_if_rdata", if_rdata, 32'd0);
        chk("a2_dm_rdata", dm_rdata, 32'd0);
        chk("a2_mem_addr", mem_addr, 32'd0);
        chk("a2_if_stall", {31'd0, if_stall}, 32'd0);
        rst = 1'b0;
        cyc(); if_req = 1'b1; if_addr = 32'h70;
        exp_q.push_back('{1'b0, model(32'h70)});
        samp();
        chk("a3_if_valid", {31'd0, if_valid}, 32'd0);
        chk("a3_mem_en", {31'd0, mem_en}, 32'd0);
        cyc(); samp();
        chk("a4_mem_en", {31'd0, mem_en}, 32'd1);
        chk("a4_mem_addr", mem_addr, 32'h70);
        cyc(); cyc(); samp();
        chk("a6_if_valid", {31'd0, if_valid}, 32'd1);
        if_req = 1'b0;
        cyc(); cyc(); samp();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 2, memory access length in cycles (legal 1..15).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have if_req in 1 (fetch request), if_addr in 32, if_rdata out 32, if_valid out 1, if_stall out 1.
REQ-005 SHALL have dm_req in 1 (data request), dm_we in 1, dm_addr in 32, dm_wdata in 32, dm_rdata out 32, dm_valid out 1, dm_stall out 1.
REQ-006 SHALL have mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32 (single-port memory side).

Function
REQ-007 SHALL implement an FSM with states IDLE, BUSY_IF and BUSY_DM.
REQ-008 In IDLE with any request, SHALL grant one port, latch its addr/we/wdata into mem_* registers and enter BUSY_<port> on the next edge.
REQ-009 Fetch grants SHALL drive mem_we=0 regardless of dm_we.
REQ-010 In BUSY_*, SHALL hold mem_en=1 and mem_* stable for exactly WAIT_CYC cycles, timed by a 4-bit down-counter loaded with WAIT_CYC-1.
REQ-011 When the counter reads 0, SHALL register mem_rdata into the granted port's rdata, pulse its valid for one cycle on the next cycle, and return to IDLE.
REQ-012 Latency SHALL be: request sampled in IDLE at cycle 0, mem_en high in cycles 1..WAIT_CYC, valid in cycle WAIT_CYC+1.
REQ-013 The FSM SHALL be in IDLE in the valid cycle and SHALL accept a new grant in it (back-to-back, one idle cycle between accesses).
REQ-014 Write grants (dm_we=1) SHALL pulse dm_valid as an acknowledge and leave dm_rdata unchanged.
REQ-015 Port rdata SHALL hold its last value until the next completed read on that port.
REQ-016 x_stall SHALL equal x_req AND NOT x_valid, combinationally, per port.
REQ-017 A requester holds req, addr, we and wdata stable until its valid; changes after the grant SHALL be ignored.
REQ-018 If req drops mid-access, the access SHALL complete and valid SHALL still pulse.
REQ-019 When both ports request in IDLE, priority SHALL follow REQ-025/REQ-026.
REQ-020 mem_en SHALL be 0 in IDLE, and mem_addr/mem_we/mem_wdata SHALL hold their last values.

Reset
REQ-021 On rst=1 at a clock edge: FSM SHALL go to IDLE, the counter SHALL clear, and all outputs SHALL be 0.
REQ-022 Reset mid-access SHALL abort the access: mem_en=0 the next cycle and no valid pulse for it.
REQ-023 The first grant after reset release SHALL occur no earlier than the first cycle with rst=0 and a request.

Configuration
REQ-024 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-025 Macro undefined: dm SHALL always win a tie (fixed priority; the older instruction drains first).
REQ-026 Macro defined: a 1-bit last-grant register SHALL give a tie to the port not granted most recently; it SHALL reset to "last=dm" so the first tie goes to if; single requests SHALL be granted regardless of it.

Verification (WAIT_CYC=2)
REQ-027 Fetch: if_req=1, if_addr=0x10, mem_rdata=0xDEADBEEF -> mem_en high for cycles 1-2, if_valid=1 and if_rdata=0xDEADBEEF in cycle 3, if_stall=1 in cycles 0-2.
REQ-028 Write: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0x55 -> mem_we=1 and mem_addr=0x40 in cycles 1-2, dm_valid in cycle 3, dm_rdata unchanged.
REQ-029 Tie, macro undefined: both requests in cycle 0 -> dm_valid in cycle 3, if_valid in cycle 6, if_stall high in cycles 0-5.
REQ-030 Tie, macro defined, both held continuously -> grant order if, dm, if, dm; valid pulses in cycles 3, 6, 9, 12 alternating.
REQ-031 Reset in cycle 1 of a read -> mem_en=0 in cycle 2, no valid pulse, all outputs 0; a fresh request after release completes with latency 3.
REQ-032 Address changed to 0x99 in cycle 1 of a fetch to 0x10 -> mem_addr stays 0x10 through cycle 2.
